fixin_scoreboard: RTL and testbench
===================================

Name: fixin_scoreboard

Overview:
- Sequential checker directly downstream of the combinational byte-fixup stage.
- The fixup stage turns an 8-bit din into a 16-bit fixin word. This block samples each (din, fixin) pair, independently recomputes the expected fixin, and compares.
- It counts matches and mismatches over a programmed run length, then reports done/pass.
- Used by the self-checking benches in place of hand-written per-cycle compares.

Parameters:
- NUM_SAMPLES, 4: samples accepted per run, >=1.
- CNT_W, 8: width of the match, mismatch and ignored counters.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a run from IDLE or DONE.
- in_valid  input  1  the (in_din, in_fixin) pair is valid this cycle.
- in_din  input  8  byte presented to the fixup stage.
- in_fixin  input  16  word produced by the fixup stage for in_din.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  high in DONE.
- pass  output  1  valid when done=1.
- match_cnt  output  CNT_W  compares that matched.
- mismatch_cnt  output  CNT_W  compares that failed.
- ignored_cnt  output  CNT_W  in_valid pulses not accepted.
- first_bad_din  output  8  din of the first mismatch (optional feature).
- first_bad_got  output  16  fixin of the first mismatch (optional feature).

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; pipeline valids 0.
- Expected-value rule:
  - base = {din, din}
  - sh = din[1:0] + 1 (range 1..4)
  - exp = ((base << sh) | ((1 << sh) - 1)) truncated to 16 bits
  - Compare is exact 16-bit equality.
- Pipeline:
  - S1 registers din/fixin/valid on an accepted sample.
  - S2 registers exp and the compare result.
  - Counters update on the next edge: counts reflect a sample 2 cycles after acceptance.
- State machine:
  - IDLE: start -> RUN; clears match_cnt, mismatch_cnt, accepted count, first-bad capture. ignored_cnt clears only on reset.
  - RUN: in_valid accepted every cycle, no backpressure. On the NUM_SAMPLES-th acceptance -> DRAIN.
  - DRAIN: exactly 2 cycles, until S1 and S2 are empty -> DONE.
  - DONE: done=1; pass = (mismatch_cnt==0) && (match_cnt==NUM_SAMPLES). start -> RUN with the same clears.
- in_valid in IDLE, DRAIN or DONE: ignored_cnt++, no compare.
- start while busy: ignored; run continues unaffected.
- start and in_valid in the same IDLE cycle: start takes effect, that sample is ignored (ignored_cnt++).
- All counters saturate at 2^CNT_W-1; no wrap.
- reset mid-run: immediate return to IDLE; all counts lost.

Optional Feature:
- Macro FIXIN_SCB_FIRSTBAD_EN.
- Defined: on the first mismatch of a run, latch din and got fixin into first_bad_din/first_bad_got. Later mismatches do not overwrite. Cleared on start.
- Undefined: both ports are constant 0; no capture registers are built.

Test Plan:
- Golden run, NUM_SAMPLES=4: reset, start, then din/fixin pairs aa/5557, fb/bfbf, 5c/b8b9, ed/b7b7 on consecutive cycles -> DONE 2 cycles after the last sample; match_cnt=4, mismatch_cnt=0, pass=1.
- Error injection: same run with fb paired to bfbe -> mismatch_cnt=1, match_cnt=3, pass=0. With FIXIN_SCB_FIRSTBAD_EN: first_bad_din=fb, first_bad_got=bfbe. Without it: both 0.
- Ignored traffic: 3 in_valid pulses in IDLE, start, then a golden run -> ignored_cnt=3, pass=1. start pulsed while busy -> no effect.
- Reset mid-run: assert reset 1 cycle after the 2nd sample -> IDLE, all outputs 0. Restart with a golden run -> pass=1.
- Saturation, CNT_W=2, NUM_SAMPLES=5: 5 golden samples -> match_cnt=3 (saturated), pass=0.
- Back-to-back runs: start in DONE, 4 samples with a gap cycle between each -> counters cleared at start; final match_cnt=4, done 2 cycles after the last sample.

Source files
------------

// File: rtl/fixin_scoreboard.sv
// -----------------------------------------------------------------------------
// fixin_scoreboard
//
// Sequential checker placed after the combinational byte-fixup stage. Each
// accepted (din, fixin) pair is carried through a two-stage pipeline. The
// expected fixin is recomputed from din and compared exactly against the
// observed word. Matches and mismatches are counted over a run of
// NUM_SAMPLES accepted samples. done/pass then report the outcome.
//
// Optional feature macro: FIXIN_SCB_FIRSTBAD_EN
//   defined   : din and fixin of the first mismatch in a run are latched into
//               first_bad_din / first_bad_got. They are cleared on start.
//   undefined : first_bad_din / first_bad_got are tied to 0 and no capture
//               registers exist.
//
// Parameters
//   NUM_SAMPLES : samples accepted per run (>= 1)
//   CNT_W       : width of match / mismatch / ignored counters
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   start         in   pulse; starts a run from IDLE or DONE, ignored when busy
//   in_valid      in   (in_din, in_fixin) valid this cycle; accepted only in RUN
//   in_din        in   [7:0]  byte fed to the fixup stage
//   in_fixin      in   [15:0] word produced by the fixup stage
//   busy          out  state is RUN or DRAIN
//   done          out  state is DONE
//   pass          out  done with zero mismatches and NUM_SAMPLES matches
//   match_cnt     out  [CNT_W-1:0] saturating count of matching compares
//   mismatch_cnt  out  [CNT_W-1:0] saturating count of failing compares
//   ignored_cnt   out  [CNT_W-1:0] saturating count of in_valid outside RUN
//   first_bad_din out  [7:0]  din of the first mismatch (optional feature)
//   first_bad_got out  [15:0] fixin of the first mismatch (optional feature)
//
// Handshake: in_valid has no ready. In RUN every in_valid cycle is accepted.
// In any other state the pulse is counted in ignored_cnt and dropped.
// -----------------------------------------------------------------------------
module fixin_scoreboard #(
   parameter int NUM_SAMPLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   input  logic [7:0]       in_din,
   input  logic [15:0]      in_fixin,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] match_cnt,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [CNT_W-1:0] ignored_cnt,
   output logic [7:0]       first_bad_din,
   output logic [15:0]      first_bad_got
);

   localparam int                ACC_W    = $clog2(NUM_SAMPLES + 1);
   localparam logic [ACC_W-1:0]  LAST_ACC = ACC_W'(NUM_SAMPLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state_q, state_d;

   // Reference model of the fixup stage.
   function automatic logic [15:0] fixin_expect(input logic [7:0] din);
      logic [15:0] base;
      logic [2:0]  sh;
      logic [15:0] mask;
      base = {din, din};
      sh   = {1'b0, din[1:0]} + 3'd1;
      mask = (16'd1 << sh) - 16'd1;
      return (base << sh) | mask;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // Pipeline and counter registers
   logic             s1_valid_q, s1_valid_d;
   logic [7:0]       s1_din_q, s1_din_d;
   logic [15:0]      s1_fixin_q, s1_fixin_d;
   logic             s2_valid_q, s2_valid_d;
   logic             s2_match_q, s2_match_d;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
   logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
   logic [CNT_W-1:0] ignored_cnt_q, ignored_cnt_d;
   logic [ACC_W-1:0] acc_cnt_q, acc_cnt_d;

   logic accept;
   logic run_start;

   assign accept    = (state_q == S_RUN) && in_valid;
   assign run_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (accept && (acc_cnt_q == LAST_ACC)) state_d = S_DRAIN;
         // S1 empty now means the final sample sits in S2. It is counted on
         // this same edge, so DRAIN lasts exactly two cycles.
         S_DRAIN: if (!s1_valid_q) state_d = S_DONE;
         S_DONE:  if (start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   // ----------------------------------------------------- datapath next
   always_comb begin
      s1_valid_d     = accept;
      s1_din_d       = s1_din_q;
      s1_fixin_d     = s1_fixin_q;
      s2_valid_d     = s1_valid_q;
      s2_match_d     = (fixin_expect(s1_din_q) == s1_fixin_q);
      match_cnt_d    = match_cnt_q;
      mismatch_cnt_d = mismatch_cnt_q;
      ignored_cnt_d  = ignored_cnt_q;
      acc_cnt_d      = acc_cnt_q;

      if (accept) begin
         s1_din_d   = in_din;
         s1_fixin_d = in_fixin;
      end

      // Any in_valid outside RUN is dropped. This includes the cycle in
      // which start is sampled.
      if (in_valid && (state_q != S_RUN)) ignored_cnt_d = sat_inc(ignored_cnt_q);

      if (run_start) begin
         // The pipeline is always empty in IDLE/DONE, so clearing is safe.
         match_cnt_d    = '0;
         mismatch_cnt_d = '0;
         acc_cnt_d      = '0;
      end else begin
         if (accept) acc_cnt_d = acc_cnt_q + ACC_W'(1);
         if (s2_valid_q) begin
            if (s2_match_q) match_cnt_d    = sat_inc(match_cnt_q);
            else            mismatch_cnt_d = sat_inc(mismatch_cnt_q);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         s1_valid_q     <= 1'b0;
         s1_din_q       <= '0;
         s1_fixin_q     <= '0;
         s2_valid_q     <= 1'b0;
         s2_match_q     <= 1'b0;
         match_cnt_q    <= '0;
         mismatch_cnt_q <= '0;
         ignored_cnt_q  <= '0;
         acc_cnt_q      <= '0;
      end else begin
         state_q        <= state_d;
         s1_valid_q     <= s1_valid_d;
         s1_din_q       <= s1_din_d;
         s1_fixin_q     <= s1_fixin_d;
         s2_valid_q     <= s2_valid_d;
         s2_match_q     <= s2_match_d;
         match_cnt_q    <= match_cnt_d;
         mismatch_cnt_q <= mismatch_cnt_d;
         ignored_cnt_q  <= ignored_cnt_d;
         acc_cnt_q      <= acc_cnt_d;
      end
   end

`ifdef FIXIN_SCB_FIRSTBAD_EN
   // S2 carries din/fixin only when they are needed for the capture.
   logic [7:0]  s2_din_q, s2_din_d;
   logic [15:0] s2_got_q, s2_got_d;
   logic        fb_seen_q, fb_seen_d;
   logic [7:0]  fb_din_q, fb_din_d;
   logic [15:0] fb_got_q, fb_got_d;

   always_comb begin
      s2_din_d  = s1_din_q;
      s2_got_d  = s1_fixin_q;
      fb_seen_d = fb_seen_q;
      fb_din_d  = fb_din_q;
      fb_got_d  = fb_got_q;
      if (run_start) begin
         fb_seen_d = 1'b0;
         fb_din_d  = '0;
         fb_got_d  = '0;
      end else if (s2_valid_q && !s2_match_q && !fb_seen_q) begin
         fb_seen_d = 1'b1;
         fb_din_d  = s2_din_q;
         fb_got_d  = s2_got_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_din_q  <= '0;
         s2_got_q  <= '0;
         fb_seen_q <= 1'b0;
         fb_din_q  <= '0;
         fb_got_q  <= '0;
      end else begin
         s2_din_q  <= s2_din_d;
         s2_got_q  <= s2_got_d;
         fb_seen_q <= fb_seen_d;
         fb_din_q  <= fb_din_d;
         fb_got_q  <= fb_got_d;
      end
   end

   assign first_bad_din = fb_din_q;
   assign first_bad_got = fb_got_q;
`else
   assign first_bad_din = 8'h00;
   assign first_bad_got = 16'h0000;
`endif

   // ------------------------------------------------------------ outputs
   assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done         = (state_q == S_DONE);
   // Compare at 32 bits so a saturated narrow counter cannot alias NUM_SAMPLES.
   assign pass         = done && (mismatch_cnt_q == '0) &&
                         (32'(match_cnt_q) == 32'(NUM_SAMPLES));
   assign match_cnt    = match_cnt_q;
   assign mismatch_cnt = mismatch_cnt_q;
   assign ignored_cnt  = ignored_cnt_q;

endmodule

// File: tb/tb_fixin_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_fixin_scoreboard
//
// Two instances share one clock:
//   dut     : NUM_SAMPLES=4, CNT_W=8
//   dut_sat : NUM_SAMPLES=5, CNT_W=2 (counter saturation)
// Stimulus pushes the expected end-of-run result for each run into a queue.
// Per-instance monitors pop and compare on the rising edge of done.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fixin_scoreboard;

   // ---------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // main instance signals
   logic        rst, start, in_valid;
   logic [7:0]  in_din;
   logic [15:0] in_fixin;
   logic        busy, done, pass;
   logic [7:0]  match_cnt, mismatch_cnt, ignored_cnt;
   logic [7:0]  fb_din;
   logic [15:0] fb_got;

   // saturation instance signals
   logic        s_rst, s_start, s_valid;
   logic [7:0]  s_din;
   logic [15:0] s_fixin;
   logic        s_busy, s_done, s_pass;
   logic [1:0]  s_match, s_mis, s_ign;
   logic [7:0]  s_fbd;
   logic [15:0] s_fbg;

   fixin_scoreboard #(.NUM_SAMPLES(4), .CNT_W(8)) dut (
      .clk(clk), .reset(rst), .start(start), .in_valid(in_valid),
      .in_din(in_din), .in_fixin(in_fixin),
      .busy(busy), .done(done), .pass(pass),
      .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt), .ignored_cnt(ignored_cnt),
      .first_bad_din(fb_din), .first_bad_got(fb_got)
   );

   fixin_scoreboard #(.NUM_SAMPLES(5), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(s_rst), .start(s_start), .in_valid(s_valid),
      .in_din(s_din), .in_fixin(s_fixin),
      .busy(s_busy), .done(s_done), .pass(s_pass),
      .match_cnt(s_match), .mismatch_cnt(s_mis), .ignored_cnt(s_ign),
      .first_bad_din(s_fbd), .first_bad_got(s_fbg)
   );

   // ------------------------------------------------------------ scoreboard
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   typedef struct packed {
      logic [7:0]  match;
      logic [7:0]  mis;
      logic [7:0]  ign;
      logic        pass;
      logic [7:0]  fbd;
      logic [15:0] fbg;
      logic [31:0] done_cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t sat_q[$];
   exp_t mon_e, sat_e;
   logic done_prev   = 1'b0;
   logic s_done_prev = 1'b0;

   // Golden vectors, hand-computed from {d,d} << (d[1:0]+1) | ones-mask.
   logic [7:0]  g_din[4] = '{8'haa, 8'hfb, 8'h5c, 8'hed};
   logic [15:0] g_fix[4] = '{16'h5557, 16'hbfbf, 16'hb8b9, 16'hb7b7};

   int exp_ign  = 0;
   int last_cyc = 0;

   // main monitor
   always @(negedge clk) begin
      if (done && !done_prev) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done rose at cycle %0d, no run expected", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("match_cnt",     32'(match_cnt),    32'(mon_e.match));
            check("mismatch_cnt",  32'(mismatch_cnt), 32'(mon_e.mis));
            check("ignored_cnt",   32'(ignored_cnt),  32'(mon_e.ign));
            check("pass",          32'(pass),         32'(mon_e.pass));
            check("first_bad_din", 32'(fb_din),       32'(mon_e.fbd));
            check("first_bad_got", 32'(fb_got),       32'(mon_e.fbg));
            check("done_cycle",    32'(cyc),          mon_e.done_cyc);
         end
      end
      done_prev = done;
   end

   // saturation monitor
   always @(negedge clk) begin
      if (s_done && !s_done_prev) begin
         if (sat_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sat_unexpected_done: done rose at cycle %0d, no run expected", cyc);
         end else begin
            sat_e = sat_q.pop_front();
            check("sat_match_cnt",    32'(s_match), 32'(sat_e.match));
            check("sat_mismatch_cnt", 32'(s_mis),   32'(sat_e.mis));
            check("sat_ignored_cnt",  32'(s_ign),   32'(sat_e.ign));
            check("sat_pass",         32'(s_pass),  32'(sat_e.pass));
            check("sat_done_cycle",   32'(cyc),     sat_e.done_cyc);
         end
      end
      s_done_prev = s_done;
   end

   // -------------------------------------------------------- driver tasks
   task automatic drive(input logic v, input logic [7:0] d, input logic [15:0] f, input logic s);
      @(negedge clk);
      in_valid = v;
      in_din   = d;
      in_fixin = f;
      start    = s;
      if (v) last_cyc = cyc;
   endtask

   task automatic drive_s(input logic v, input logic [7:0] d, input logic [15:0] f, input logic s);
      @(negedge clk);
      s_valid = v;
      s_din   = d;
      s_fixin = f;
      s_start = s;
      if (v) last_cyc = cyc;
   endtask

   // Four golden samples; bad_idx >= 0 flips bit 0 of that sample's fixin.
   // busy_start also pulses start on sample 2 and in the first DRAIN cycle.
   task automatic run(input int gap, input int bad_idx, input bit busy_start);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, g_din[i], (i == bad_idx) ? (g_fix[i] ^ 16'h0001) : g_fix[i],
               busy_start && (i == 1));
         if (i < 3) repeat (gap) drive(1'b0, 8'h00, 16'h0000, 1'b0);
      end
      e = '0;
      e.match = (bad_idx >= 0) ? 8'd3 : 8'd4;
      e.mis   = (bad_idx >= 0) ? 8'd1 : 8'd0;
      e.ign   = 8'(exp_ign);
      e.pass  = (bad_idx < 0);
`ifdef FIXIN_SCB_FIRSTBAD_EN
      if (bad_idx >= 0) begin
         e.fbd = g_din[bad_idx];
         e.fbg = g_fix[bad_idx] ^ 16'h0001;
      end
`endif
      // accepted at posedge last_cyc+1, done after posedge last_cyc+3
      e.done_cyc = 32'(last_cyc + 3);
      exp_q.push_back(e);
      drive(1'b0, 8'h00, 16'h0000, busy_start);
      drive(1'b0, 8'h00, 16'h0000, 1'b0);
   endtask

   task automatic wait_done(input bit sat);
      int n;
      n = 0;
      while (!(sat ? s_done : done) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!(sat ? s_done : done)) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got done=0 expected done=1 within 20 cycles (sat=%0d)", sat);
      end
   endtask

   // ------------------------------------------------------------ sequence
   initial begin
      exp_t e;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_din = '0; in_fixin = '0;
      s_rst = 1'b1; s_start = 1'b0; s_valid = 1'b0; s_din = '0; s_fixin = '0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_busy",     32'(busy),         0);
      check("rst_done",     32'(done),         0);
      check("rst_pass",     32'(pass),         0);
      check("rst_match",    32'(match_cnt),    0);
      check("rst_mismatch", 32'(mismatch_cnt), 0);
      check("rst_ignored",  32'(ignored_cnt),  0);
      check("rst_fb_din",   32'(fb_din),       0);
      check("rst_fb_got",   32'(fb_got),       0);
      rst = 1'b0;
      s_rst = 1'b0;

      // golden run
      drive(1'b0, 8'h00, 16'h0000, 1'b1);
      run(0, -1, 1'b0);
      wait_done(1'b0);

      // error injection: fb paired with bfbe
      drive(1'b0, 8'h00, 16'h0000, 1'b1);
      run(0, 1, 1'b0);
      wait_done(1'b0);

      // ignored traffic in IDLE, then golden run with start pulses while busy
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'h11 * 8'(i + 1), 16'h1234, 1'b0);
         drive(1'b0, 8'h00, 16'h0000, 1'b0);
      end
      exp_ign = 3;
      check("idle_ignored", 32'(ignored_cnt), 3);
      check("idle_busy",    32'(busy),        0);
      drive(1'b0, 8'h00, 16'h0000, 1'b1);
      run(0, -1, 1'b1);
      wait_done(1'b0);

      // reset one cycle after the second sample
      drive(1'b0, 8'h00, 16'h0000, 1'b1);
      drive(1'b1, g_din[0], g_fix[0], 1'b0);
      drive(1'b1, g_din[1], g_fix[1], 1'b0);
      drive(1'b0, 8'h00, 16'h0000, 1'b0);
      @(negedge clk);
      check("midrun_match_latency", 32'(match_cnt), 1);
      check("midrun_busy",          32'(busy),      1);
      rst = 1'b1;
      #1;
      check("midrun_rst_busy",    32'(busy),         0);
      check("midrun_rst_done",    32'(done),         0);
      check("midrun_rst_match",   32'(match_cnt),    0);
      check("midrun_rst_mis",     32'(mismatch_cnt), 0);
      check("midrun_rst_ignored", 32'(ignored_cnt),  0);
      @(negedge clk) rst = 1'b0;
      exp_ign = 0;
      drive(1'b0, 8'h00, 16'h0000, 1'b1);
      run(0, -1, 1'b0);
      wait_done(1'b0);

      // back-to-back: start with in_valid in DONE, samples with gap cycles
      drive(1'b1, 8'h33, 16'h0000, 1'b1);
      exp_ign = 1;
      drive(1'b0, 8'h00, 16'h0000, 1'b0);
      check("b2b_cleared_match", 32'(match_cnt),    0);
      check("b2b_cleared_mis",   32'(mismatch_cnt), 0);
      check("b2b_busy",          32'(busy),         1);
      check("b2b_ignored",       32'(ignored_cnt),  1);
      run(1, -1, 1'b0);
      wait_done(1'b0);

      // saturation: CNT_W=2, five golden samples
      drive_s(1'b0, 8'h00, 16'h0000, 1'b1);
      for (int i = 0; i < 5; i++) drive_s(1'b1, g_din[i % 4], g_fix[i % 4], 1'b0);
      e = '0;
      e.match    = 8'd3;
      e.done_cyc = 32'(last_cyc + 3);
      sat_q.push_back(e);
      drive_s(1'b0, 8'h00, 16'h0000, 1'b0);
      wait_done(1'b1);

      repeat (3) @(negedge clk);
      check("exp_q_left", 32'(exp_q.size()), 0);
      check("sat_q_left", 32'(sat_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
